// File: rtl/cla_accumulator_if.sv
// Sample-in / total-out handshake bundle for cla_accumulator.
// master = upstream/downstream side, slave = accumulator side.
interface cla_accumulator_if #(
  parameter int WIDTH = 3,
  parameter int ACC_W = 5
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data;
  logic             i_clear;
  logic             o_valid;
  logic             i_ready;
  logic [ACC_W-1:0] o_sum;
  logic             o_overflow;

  modport master (
    output i_valid, i_data, i_clear, i_ready,
    input  o_ready, o_valid, o_sum, o_overflow
  );

  modport slave (
    input  i_valid, i_data, i_clear, i_ready,
    output o_ready, o_valid, o_sum, o_overflow
  );
endinterface

// File: rtl/cla_accumulator.sv
// Burst accumulator: sums COUNT unsigned samples through a carry-lookahead
// adder and hands the wrapped total plus a sticky carry flag downstream.

// Flat carry-lookahead adder; o_result[WIDTH] is the carry-out.
module carry_lookahead_adder #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  output logic [WIDTH:0]   o_result
);
  logic [WIDTH-1:0] gen, prp;
  logic [WIDTH:0]   carry;

  assign gen = i_add1 & i_add2;
  assign prp = i_add1 ^ i_add2;

  // AND of propagate bits lo..hi inclusive.
  function automatic logic span_and(input logic [WIDTH-1:0] v, input int lo, input int hi);
    logic r;
    r = 1'b1;
    for (int k = 0; k < WIDTH; k++)
      if (k >= lo && k <= hi) r &= v[k];
    return r;
  endfunction

  // Each carry expanded as a sum of generate terms, no rippling through lower carries.
  always_comb begin
    carry = '0;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = gen[i];
      for (int j = 0; j < i; j++)
        carry[i+1] = carry[i+1] | (gen[j] & span_and(prp, j + 1, i));
    end
  end

  assign o_result = {carry[WIDTH], prp ^ carry[WIDTH-1:0]};
endmodule

module cla_accumulator #(
  parameter int WIDTH = 3,
  parameter int COUNT = 4,
  parameter int ACC_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  cla_accumulator_if.slave   bus
);
  localparam int CNT_W = $clog2(COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [0:0]       state_q, state_d;
  logic [ACC_W:0]   add_res;

  // The adder output feeds acc_d directly; nothing sits between them.
  carry_lookahead_adder #(.WIDTH(ACC_W)) u_adder (
    .i_add1   (acc_q),
    .i_add2   (ACC_W'(bus.i_data)),
    .o_result (add_res)
  );

  // Next-state: clear beats everything, then accept in ACCUM / take in HOLD.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    state_d = state_q;
    if (bus.i_clear) begin
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      state_d = ACCUM;
    end else if (state_q == ACCUM) begin
      if (bus.i_valid) begin
        acc_d = add_res[ACC_W-1:0];
        ovf_d = ovf_q | add_res[ACC_W];
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end else if (bus.i_ready) begin
      acc_d   = '0;
      ovf_d   = 1'b0;
      state_d = ACCUM;
    end
  end

  // State register, asynchronously cleared.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      state_q <= ACCUM;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  // Handshake depends on state only; totals come straight from the flops.
  assign bus.o_ready    = (state_q == ACCUM);
  assign bus.o_valid    = (state_q == HOLD);
  assign bus.o_sum      = acc_q;
  assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_cla_accumulator.sv
// Bench for cla_accumulator: two instances (ACC_W=5 and ACC_W=4) share one
// stimulus stream; an unwrapped-sum model is compared every cycle.
module tb_cla_accumulator;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic       clear = 1'b0;
  logic       rdy = 1'b0;
  logic [2:0] data = 3'd0;
  bit         cmp_en = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cla_accumulator_if #(.WIDTH(3), .ACC_W(5)) bus5 ();
  cla_accumulator_if #(.WIDTH(3), .ACC_W(4)) bus4 ();

  assign bus5.i_valid = valid;
  assign bus5.i_data  = data;
  assign bus5.i_clear = clear;
  assign bus5.i_ready = rdy;
  assign bus4.i_valid = valid;
  assign bus4.i_data  = data;
  assign bus4.i_clear = clear;
  assign bus4.i_ready = rdy;

  cla_accumulator #(.WIDTH(3), .COUNT(4), .ACC_W(5)) u_dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus5.slave));
  cla_accumulator #(.WIDTH(3), .COUNT(4), .ACC_W(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus4.slave));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
  endtask

  // Model: true (unwrapped) burst total, samples taken so far, total pending.
  int m_total;
  int m_n;
  bit m_hold;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_total <= 0; m_n <= 0; m_hold <= 1'b0;
    end else if (clear) begin
      m_total <= 0; m_n <= 0; m_hold <= 1'b0;
    end else if (!m_hold) begin
      if (valid) begin
        m_total <= m_total + int'(data);
        if (m_n == 3) begin m_n <= 0; m_hold <= 1'b1; end
        else m_n <= m_n + 1;
      end
    end else if (rdy) begin
      m_total <= 0; m_hold <= 1'b0;
    end
  end

  // Per-cycle compare away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc.ready5", int'(bus5.o_ready), int'(!m_hold));
      chk("cyc.valid5", int'(bus5.o_valid), int'(m_hold));
      chk("cyc.ready4", int'(bus4.o_ready), int'(!m_hold));
      chk("cyc.valid4", int'(bus4.o_valid), int'(m_hold));
      if (m_hold) begin
        chk("cyc.sum5", int'(bus5.o_sum), m_total % 32);
        chk("cyc.ovf5", int'(bus5.o_overflow), int'(m_total >= 32));
        chk("cyc.sum4", int'(bus4.o_sum), m_total % 16);
        chk("cyc.ovf4", int'(bus4.o_overflow), int'(m_total >= 16));
      end
    end
  end

  task automatic burst(input int a, input int b, input int c, input int d);
    int s[4];
    s = '{a, b, c, d};
    for (int k = 0; k < 4; k++) begin
      valid = 1'b1;
      data  = 3'(s[k]);
      @(posedge clk); #1;
    end
    valid = 1'b0;
  endtask

  // Hand-computed totals, checked one cycle after the last accept.
  task automatic pin(input string tag, input int s5, input int o5, input int s4, input int o4);
    chk({tag, ".valid"}, int'(bus5.o_valid), 1);
    chk({tag, ".sum5"},  int'(bus5.o_sum), s5);
    chk({tag, ".ovf5"},  int'(bus5.o_overflow), o5);
    chk({tag, ".sum4"},  int'(bus4.o_sum), s4);
    chk({tag, ".ovf4"},  int'(bus4.o_overflow), o4);
    chk({tag, ".model"}, m_total % 32, s5);
  endtask

  task automatic take();
    rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    chk("take.valid", int'(bus5.o_valid), 0);
    chk("take.ready", int'(bus5.o_ready), 1);
  endtask

  int  k;
  int  guard;
  bit  acc_now;

  initial begin
    #12;
    chk("rst.ready", int'(bus5.o_ready), 1);
    chk("rst.valid", int'(bus5.o_valid), 0);
    chk("rst.sum",   int'(bus5.o_sum), 0);
    chk("rst.ovf",   int'(bus5.o_overflow), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cmp_en = 1'b1;

    burst(1, 2, 3, 4); pin("b1234", 10, 0, 10, 0); take();

    // Back-pressure: samples offered during HOLD must be ignored.
    burst(7, 7, 7, 7); pin("b7777", 28, 0, 12, 1);
    valid = 1'b1; data = 3'd5;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp.ready", int'(bus5.o_ready), 0);
      chk("bp.sum5", int'(bus5.o_sum), 28);
      chk("bp.sum4", int'(bus4.o_sum), 12);
    end
    valid = 1'b0;
    take();
    burst(0, 0, 0, 0); pin("b0000", 0, 0, 0, 0); take();
    burst(1, 1, 1, 1); pin("b1111", 4, 0, 4, 0); take();

    // Clear mid-burst, with a sample offered in the clear cycle.
    valid = 1'b1; data = 3'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; valid = 1'b0;
    burst(1, 1, 1, 1); pin("clr1", 4, 0, 4, 0);
    // Clear in HOLD together with i_ready: total is dropped.
    clear = 1'b1; rdy = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; rdy = 1'b0;
    chk("clrh.valid", int'(bus5.o_valid), 0);
    chk("clrh.ready", int'(bus5.o_ready), 1);
    burst(2, 3, 0, 1); pin("clr2", 6, 0, 6, 0); take();

    // Asynchronous reset mid-burst.
    valid = 1'b1; data = 3'd5;
    repeat (3) begin @(posedge clk); #1; end
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", int'(bus5.o_valid), 0);
    chk("arst.ready", int'(bus5.o_ready), 1);
    chk("arst.sum5",  int'(bus5.o_sum), 0);
    chk("arst.sum4",  int'(bus4.o_sum), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    burst(2, 2, 2, 2); pin("arst2", 8, 0, 8, 0); take();

    // Every 4-sample sequence with random input and output gaps.
    for (int seq = 0; seq < 4096; seq++) begin
      k = 0;
      guard = 0;
      while (k < 4 && guard < 200) begin
        valid = ($urandom_range(3) != 0);
        data  = 3'((seq >> (3 * k)) & 7);
        rdy   = 1'($urandom_range(1));
        acc_now = valid && !m_hold;
        @(posedge clk); #1;
        if (acc_now) k++;
        guard++;
      end
      valid = 1'b0;
      guard = 0;
      while (m_hold && guard < 200) begin
        rdy = 1'($urandom_range(1));
        @(posedge clk); #1;
        guard++;
      end
      rdy = 1'b0;
      chk("exh.drain", int'(bus5.o_valid), 0);
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cla_accumulator.md
# cla_accumulator

Sequential front-end that owns a `carry_lookahead_adder` instance and drives its `i_add1`/`i_add2` inputs. It accepts a stream of WIDTH-bit samples over a valid/ready handshake and sums each burst of COUNT samples. It registers the adder's `o_result` into a running accumulator and presents the burst total downstream over a second valid/ready handshake.

## Interface
- WIDTH, 3, sample width in bits.
- COUNT, 4, samples per burst; must be at least 2.
- ACC_W, 5, accumulator width. Must be at least WIDTH. The adder is instantiated with WIDTH=ACC_W.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset: asynchronous assert, active-low.
- i_valid  input  1  sample valid.
- o_ready  output  1  block can accept a sample.
- i_data  input  WIDTH  sample, unsigned.
- i_clear  input  1  synchronous abort: discard the current burst.
- o_valid  output  1  burst total valid.
- i_ready  input  1  downstream accepts the total.
- o_sum  output  ACC_W  burst total, modulo 2^ACC_W.
- o_overflow  output  1  a carry-out occurred during this burst.

## Operation
- Adder hookup:
  - `i_add1` = acc.
  - `i_add2` = i_data zero-extended to ACC_W.
  - `o_result[ACC_W-1:0]` is the next acc.
  - `o_result[ACC_W]` is the carry-out.
- State register holds acc[ACC_W-1:0], cnt[$clog2(COUNT)-1:0], ovf, and a 2-state FSM {ACCUM, HOLD}.
- ACCUM state:
  - o_ready=1, o_valid=0.
  - Accept when i_valid && o_ready: acc ← o_result[ACC_W-1:0], ovf ← ovf | o_result[ACC_W], cnt ← cnt+1.
  - On the accept where cnt==COUNT-1: cnt ← 0, FSM → HOLD.
  - Without an accept, all state is unchanged.
- HOLD state:
  - o_ready=0, o_valid=1, o_sum=acc, o_overflow=ovf.
  - o_sum and o_overflow stay stable until the total is taken.
  - On i_ready: acc ← 0, ovf ← 0, FSM → ACCUM.
- i_clear has priority over every other event in either state. The next state is acc=0, cnt=0, ovf=0, ACCUM. A sample presented in the same cycle is not accepted, and a pending total is dropped.
- Wrap-around: acc wraps modulo 2^ACC_W. The ovf flag is sticky for the burst and cleared only when the total is taken, on clear, or on reset.
- o_sum and o_overflow are driven from registers in every state. Their value outside HOLD is don't-care for checkers.

## Timing
- Reset (i_rst_n=0), applied at any time and asynchronously: acc=0, cnt=0, ovf=0, FSM=ACCUM. Outputs become o_ready=1, o_valid=0, o_sum=0, o_overflow=0.
- A reset mid-burst discards the partial sum.
- Throughput in ACCUM is one sample per cycle.
- Latency: if the last sample is accepted on edge N, o_valid=1 is visible after edge N, for the cycle N..N+1.
- The total is transferred on the edge where o_valid && i_ready.
- o_ready returns to 1 in the cycle after that edge, so each burst has at least 1 bubble cycle.
- o_ready is a function of FSM state only. o_valid does not depend on i_ready.
- The combinational path i_data → adder → acc must close in one cycle. The adder output is never registered separately.

## Test plan
- Defaults, samples 1,2,3,4 presented back-to-back → o_valid one cycle after the 4th accept, o_sum=10, o_overflow=0.
- Defaults, samples 7,7,7,7 → o_sum=28, o_overflow=0. Then samples 0,0,0,0 → o_sum=0, so acc is shown to have been cleared between bursts.
- ACC_W=4, samples 7,7,7,7 → o_sum=12 (28 mod 16), o_overflow=1. The next burst 1,1,1,1 → o_sum=4, o_overflow=0.
- Back-pressure: hold i_ready=0 for 5 cycles in HOLD with i_valid=1 and data=5 → o_ready=0, no sample consumed, o_sum stable. After i_ready=1 the next burst starts with acc=0.
- Assert i_clear after 2 samples (3,3), then send 1,1,1,1 → o_sum=4. Separately, assert i_clear in HOLD → o_valid drops the next cycle and no total is transferred.
- Pulse i_rst_n low asynchronously after 3 samples → o_valid=0, o_ready=1, o_sum=0 immediately. Then samples 2,2,2,2 → o_sum=8.
- Exhaustive: all 8^4 sample sequences under defaults, with random i_valid/i_ready gaps, checked against a reference model: o_sum equals the sum mod 32, and o_overflow is set iff the sum is ≥ 32.
